// File: rtl/adder_pkg.sv
// Shared constants and helpers for the sliced pipelined adder.
package adder_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int slice_width(input int bus_width, input int stages);
      return bus_width / stages;
   endfunction

endpackage

// File: rtl/add_slice.sv
// W-bit combinational adder slice; exposes carry into the MSB for overflow detection.
module add_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         msb_cin
);

   logic [W:0] full;

   assign full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   assign sum     = full[W-1:0];
   assign cout    = full[W];
   // The carry into the top bit is recovered from the sum bit and its operands.
   assign msb_cin = a[W-1] ^ b[W-1] ^ sum[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract pipeline: one W-bit slice per stage, operands skewed in, results deskewed out.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int BUS_WIDTH = 32,
   parameter int STAGES    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BUS_WIDTH-1:0] a,
   input  logic [BUS_WIDTH-1:0] b,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BUS_WIDTH-1:0] sum,
   output logic                 carry,
   output logic                 overflow,
   output logic                 zero
);

   localparam int W = slice_width(BUS_WIDTH, STAGES);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
   // The whole pipe advances together unless a finished result is waiting unclaimed.
   logic advance;

   assign in_ready = !(out_valid && !out_ready);
   assign advance  = in_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int OPW = (STAGES - k) * W;
      localparam int RW  = (k + 1) * W;

      logic [OPW-1:0] a_src;
      logic [OPW-1:0] b_src;
      logic           c_src;
      logic           v_src;
      logic [W-1:0]   s;
      logic           co;
      logic           cm;
      logic [RW-1:0]  r_next;
      logic [RW-1:0]  r_q;
      logic           valid_q;
      logic           carry_q;

      if (k == 0) begin : g_in
         assign a_src  = a;
         assign b_src  = (sub == MODE_SUB) ? ~b : b;
         assign c_src  = sub;
         assign v_src  = in_valid;
         assign r_next = s;
      end else begin : g_chain
         assign a_src  = g_stage[k-1].g_skew.a_q;
         assign b_src  = g_stage[k-1].g_skew.b_q;
         assign c_src  = g_stage[k-1].carry_q;
         assign v_src  = g_stage[k-1].valid_q;
         assign r_next = {s, g_stage[k-1].r_q};
      end

      add_slice #(
         .W(W)
      ) u_slice (
         .a       (a_src[W-1:0]),
         .b       (b_src[W-1:0]),
         .cin     (c_src),
         .sum     (s),
         .cout    (co),
         .msb_cin (cm)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            r_q     <= '0;
         end else if (advance) begin
            valid_q <= v_src;
            carry_q <= co;
            r_q     <= r_next;
         end
      end

      // Operand slices not yet consumed travel alongside the partial result.
      if (k < STAGES - 1) begin : g_skew
         logic [OPW-W-1:0] a_q;
         logic [OPW-W-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_src[OPW-1:W];
               b_q <= b_src[OPW-1:W];
            end
         end
      end else begin : g_flags
         logic ovf_q;
         logic zero_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (advance) begin
               ovf_q  <= co ^ cm;
               zero_q <= ~|r_next;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].valid_q;
   assign sum       = g_stage[STAGES-1].r_q;
   assign carry     = g_stage[STAGES-1].carry_q;
   assign overflow  = g_stage[STAGES-1].g_flags.ovf_q;
   assign zero      = g_stage[STAGES-1].g_flags.zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomized checks of the 32-bit, 4-stage pipelined adder.
module tb_pipelined_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        carry;
   logic        overflow;
   logic        zero;

   int checks = 0;
   int errors = 0;

   logic [34:0] exp_q[$];

   pipelined_adder #(
      .BUS_WIDTH (32),
      .STAGES    (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: full-width add of a and the (possibly inverted) b; returns {zero, ovf, carry, sum}.
   function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
      logic [31:0] bb;
      logic [32:0] full;
      logic        v;
      bb   = ms ? ~mb : mb;
      full = {1'b0, ma} + {1'b0, bb} + {32'd0, ms};
      v    = (ma[31] == bb[31]) && (full[31] != ma[31]);
      return {(full[31:0] == 32'd0), v, full[32], full[31:0]};
   endfunction

   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_b,
                         input logic ts, input logic [31:0] es, input logic ec,
                         input logic ev, input logic ez);
      int lat;
      @(negedge clk);
      a = ta; b = tb_b; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
      #1 check({tag, " in_ready"}, in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, lat, 4);
      check({tag, " sum"}, sum, es);
      check({tag, " carry"}, carry, ec);
      check({tag, " overflow"}, overflow, ev);
      check({tag, " zero"}, zero, ez);
   endtask

   logic [31:0] stream_exp[8] = '{32'h101, 32'h102, 32'h103, 32'h104,
                                  32'h105, 32'h106, 32'h107, 32'h108};

   initial begin
      int issued;
      int drained;
      int cyc;
      int seen;
      logic acc;
      logic drn;
      logic [34:0] head;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;

      // Reset state
      #12;
      check("rst out_valid", out_valid, 0);
      check("rst sum", sum, 0);
      check("rst flags", {carry, overflow, zero}, 0);
      check("rst in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed single operations
      run_op("add 1+2",         32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0);
      run_op("add ffffffff+1",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      run_op("add 7fffffff+1",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      run_op("sub 5-5",         32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
      run_op("sub 3-5",         32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
      run_op("sub 80000000-1",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
      run_op("add slice carry", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);

      // Back-to-back stream with a consumer stall in cycles 6-9
      @(negedge clk);
      issued = 0; drained = 0; cyc = 1;
      while (drained < 8 && cyc < 60) begin
         in_valid  = (issued < 8);
         a         = issued + 1;
         b         = 32'h00000100;
         sub       = 1'b0;
         out_ready = !(cyc >= 6 && cyc <= 9);
         #1;
         if (cyc >= 6 && cyc <= 9) begin
            check("stall out_valid", out_valid, 1);
            check("stall in_ready", in_ready, 0);
            check("stall held sum", sum, stream_exp[1]);
         end
         acc = in_valid && in_ready;
         drn = out_valid && out_ready;
         if (drn) begin
            check("stream sum", sum, stream_exp[drained]);
            drained++;
         end
         @(posedge clk);
         if (acc) issued++;
         @(negedge clk);
         cyc++;
      end
      check("stream drained", drained, 8);
      in_valid = 1'b0;
      #1 check("stream idle", out_valid, 0);

      // Reset pulsed between edges with work in flight
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; a = 32'h10 + i; b = 32'h1; sub = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("pre-reset out_valid", out_valid, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async rst out_valid", out_valid, 0);
      check("async rst sum", sum, 0);
      check("async rst in_ready", in_ready, 1);
      #1 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no stale result", seen, 0);
      run_op("post-reset 1+2", 32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0);

      // Random traffic against the reference model
      @(negedge clk);
      issued = 0; drained = 0;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a   = $urandom();
         b   = ($urandom_range(0, 7) == 0) ? a : $urandom();
         sub = $urandom_range(0, 1) == 1;
         #1;
         acc = in_valid && in_ready;
         drn = out_valid && out_ready;
         if (drn) begin
            head = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            check("random result", {zero, overflow, carry, sum}, head);
            drained++;
         end
         if (acc) begin
            exp_q.push_back(model(a, b, sub));
            issued++;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         #1;
         if (out_valid) begin
            head = exp_q.pop_front();
            check("random drain", {zero, overflow, carry, sum}, head);
            drained++;
         end
         @(negedge clk);
      end
      check("random count", drained, issued);
      check("random queue empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the number of pipeline slices; BUS_WIDTH SHALL be an integer multiple of STAGES, with STAGES from 1 to BUS_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and mode presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, inputs, BUS_WIDTH bits each: the operands.
REQ-008 The block SHALL have port sub, input, 1 bit: 0 selects a+b, 1 selects a-b.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result and flags valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The block SHALL have port sum, output, BUS_WIDTH bits: the result modulo 2^BUS_WIDTH.
REQ-012 The block SHALL have ports carry, overflow and zero, outputs, 1 bit each: the result flags.

Function
REQ-013 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-014 Subtraction SHALL be computed as a + ~b + 1.
REQ-015 Slice k (width W = BUS_WIDTH/STAGES) SHALL be added in pipeline stage k, with the carry from stage k-1 registered between stages.
REQ-016 The upper operand slices SHALL be skewed through registers, and the lower result slices deskewed, so that all bits of one result emerge together.
REQ-017 With no stall, latency SHALL be exactly STAGES cycles from acceptance to out_valid=1 with that result.
REQ-018 Sustained throughput SHALL be one operation per cycle.
REQ-019 carry SHALL be the carry out of the MSB; for sub=1, carry=1 means no borrow.
REQ-020 overflow SHALL be 1 when signed two's-complement overflow occurs (operand sign bits, post-inversion of b, equal and the result sign differs).
REQ-021 zero SHALL be 1 when sum equals 0.
REQ-022 Stall: while out_valid=1 and out_ready=0, every pipeline register SHALL hold its value and in_ready SHALL be 0.
REQ-023 Otherwise in_ready SHALL be 1, so that in_ready = !(out_valid && !out_ready).
REQ-024 Bubbles (stages holding no operation) SHALL propagate with a per-stage valid bit, and a bubble SHALL never raise out_valid.
REQ-025 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-026 Simultaneous accept and drain in the same cycle SHALL both take effect.
REQ-027 With STAGES=1 the block SHALL be a single registered adder with latency 1.

Reset
REQ-028 While rst_n=0, all stage valid bits and out_valid SHALL be 0, and sum, carry, overflow and zero SHALL be 0, taking effect immediately and without waiting for clk.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations.
REQ-030 After rst_n deasserts, the first accepted operation SHALL appear STAGES cycles later.
REQ-031 in_ready SHALL be 1 during and after reset.

Structure
REQ-032 Package adder_pkg SHALL hold the mode constants (MODE_ADD=0, MODE_SUB=1) and a function computing slice width from BUS_WIDTH and STAGES.
REQ-033 One sub-module add_slice SHALL be used: a W-bit combinational adder with carry in, carry out and MSB carry-in exposed, instantiated STAGES times.

Verification (BUS_WIDTH=32, STAGES=4)
REQ-034 The bench SHALL cover: rst_n low, then 0x00000001 + 0x00000002, out_ready=1 -> out_valid exactly 4 cycles after accept, sum=0x00000003, carry=overflow=zero=0.
REQ-035 The bench SHALL cover: 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, carry=1, zero=1, overflow=0 (carry rippled across all 4 slices).
REQ-036 The bench SHALL cover: 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, overflow=1, carry=0; and sub, 0x00000005 - 0x00000005 -> sum=0, zero=1, carry=1.
REQ-037 The bench SHALL cover: back-to-back stream of 8 ops with out_ready=0 for cycles 6-9 -> in_ready=0 and outputs frozen during the stall, all 8 results in order, no loss.
REQ-038 The bench SHALL cover: 3 ops in flight, rst_n pulsed low asynchronously between edges -> out_valid=0 immediately; no stale result after release.
REQ-039 The bench SHALL cover: random ops against a reference model with random in_valid/out_ready -> every sum and flag matches, count in equals count out.
